ctl_bus_writer: RTL and testbench
=================================

Name: ctl_bus_writer

Overview:
- Bus-side initiator for the control BRAM interface (cpu_bus_if signal set, port A).
- Issues single register writes and runs the complete synchronize sequence:
  - writes the EtherCAT sync time and the per-transducer cycle table;
  - sets the CTL_REG sync bit by read-modify-write;
  - polls CTL_REG until the FPGA-side controller clears the sync bit.
- Sits between the host command decoder and the control BRAM. The bus clock is CLK.

Parameters:
WIDTH, 13, cycle table word width
DEPTH, 249, number of cycle table entries
RD_LATENCY, 2, cycles from a registered read address to valid DATA_OUT
ADDR_CTL_REG, 10'h000, CTL_REG word address
ADDR_FPGA_INFO, 10'h001, FPGA_INFO word address
ADDR_EC_SYNC_TIME_0, 10'h011, first of 4 consecutive sync time words, LSW first
ADDR_CYCLE_BASE, 10'h100, cycle table base address
SYNC_BIT, 8, bit index of the sync request in CTL_REG
TIMEOUT, 4096, maximum poll cycles before error

Ports:
CLK  in  1  system clock, also the bus clock
RST_N  in  1  asynchronous active-low reset
REQ_VALID  in  1  single write request
REQ_READY  out  1  high only in IDLE when SYNC_REQ is low
REQ_ADDR  in  10  write address; bit 9 selects the delay BRAM
REQ_DATA  in  16  write data
SYNC_REQ  in  1  start-sync pulse, sampled in IDLE only
SYNC_TIME  in  64  sync time, captured on SYNC_REQ acceptance
CYC_VALID  in  1  cycle table stream valid
CYC_READY  out  1  cycle table stream ready
CYC_DATA  in  WIDTH  cycle table word
SYNC_BUSY  out  1  high from acceptance until SYNC_DONE/SYNC_ERR
SYNC_DONE  out  1  one-cycle pulse: sync bit observed cleared
SYNC_ERR  out  1  one-cycle pulse: poll timeout
CTL_EN  out  1  bus enable
WE  out  1  bus write enable
BRAM_ADDR  out  10  bus address
DATA_IN  out  16  bus write data into BRAM
DATA_OUT  in  16  bus read data from BRAM

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE; counters are 0.
  - REQ_READY rises on the first cycle after reset release.
- All bus outputs are registered. A write takes one cycle with CTL_EN=1 and WE=1. A read is one cycle with CTL_EN=1 and WE=0; DATA_OUT is sampled RD_LATENCY cycles later, with CTL_EN=0 while waiting.
- IDLE:
  - SYNC_REQ has priority over REQ_VALID.
  - A write handshake (REQ_VALID & REQ_READY) is driven on the bus in the next cycle. Back-to-back writes run at 1 per cycle.
  - SYNC_REQ latches SYNC_TIME and moves to SYNC_TIME_WR.
- SYNC_TIME_WR:
  - 4 consecutive writes to ADDR_EC_SYNC_TIME_0+k, data SYNC_TIME[16k+15:16k], k=0..3.
  - Then moves to CYCLE_WR.
- CYCLE_WR:
  - CYC_READY is high.
  - Each CYC_VALID & CYC_READY writes {zero-extended CYC_DATA} to ADDR_CYCLE_BASE+idx, then idx increments.
  - A cycle with CYC_VALID low issues no bus access and holds idx.
  - After entry DEPTH-1, CYC_READY drops in the same cycle and the state moves to RD_CTL.
- RD_CTL: read ADDR_CTL_REG, wait RD_LATENCY, capture the value as v.
- SET_SYNC: write ADDR_CTL_REG with v | (1<<SYNC_BIT).
- POLL:
  - Read ADDR_CTL_REG, wait RD_LATENCY, test DATA_OUT[SYNC_BIT].
  - Bit clear: pulse SYNC_DONE and return to IDLE.
  - Bit set: re-issue the read.
  - The poll counter increments every cycle in POLL. Reaching TIMEOUT-1 pulses SYNC_ERR and returns to IDLE; no clear is attempted.
- SYNC_REQ outside IDLE is ignored.
- CYC_VALID outside CYCLE_WR is not consumed.
- Reset mid-sequence aborts immediately. CTL_EN and WE drop asynchronously, and no partial completion pulse is produced.

Optional Feature:
- Macro: CTL_BUS_WRITER_THERMO_POLL_EN.
- Enabled:
  - Adds output THERMO_OUT (1 bit, reset 0).
  - A 16-bit free-running counter runs; each time it wraps, while IDLE with no pending request, the block reads ADDR_FPGA_INFO.
  - THERMO_OUT takes DATA_OUT[0].
  - REQ_READY is low during that read.
- Disabled: no port, no counter, and no FPGA_INFO access.

Test Plan:
- Single write: REQ_ADDR=10'h005, REQ_DATA=16'hBEEF -> next cycle CTL_EN=1, WE=1, BRAM_ADDR=10'h005, DATA_IN=16'hBEEF. 3 back-to-back requests -> 3 consecutive bus writes.
- Sync sequence:
  - Stimulus: SYNC_TIME=64'h0123_4567_89AB_CDEF, cycle stream 0..248.
  - Required: writes CDEF, 89AB, 4567, 0123 to addresses 011–014, then cycle[i]=i at 100+i.
  - Then CTL_REG read returning 16'h0003 -> write 16'h0103.
  - BRAM model clears bit 8 after 300 cycles -> single SYNC_DONE pulse; SYNC_BUSY was high throughout.
- Stream stall: CYC_VALID low for 5 cycles at entry 100 -> no bus access during the stall; all 249 entries written exactly once, in order.
- Timeout: sync bit never cleared -> SYNC_ERR exactly TIMEOUT cycles after POLL entry; no SYNC_DONE; returns to IDLE.
- Priority/ignore: SYNC_REQ and REQ_VALID asserted together in IDLE -> sync starts, REQ_READY low. A second SYNC_REQ mid-sequence -> no effect.
- Reset during CYCLE_WR at entry 50 -> all outputs 0 immediately; after release, a fresh sync completes normally.

Source files
------------

// File: rtl/ctl_bus_writer.sv
// Control BRAM bus initiator: single writes plus the sync-time / cycle-table / CTL_REG handshake.
// Optional FPGA_INFO thermo poll enabled by defining CTL_BUS_WRITER_THERMO_POLL_EN.
module ctl_bus_writer #(
  parameter int unsigned WIDTH               = 13,
  parameter int unsigned DEPTH               = 249,
  parameter int unsigned RD_LATENCY          = 2,
  parameter logic [9:0]  ADDR_CTL_REG        = 10'h000,
`ifdef CTL_BUS_WRITER_THERMO_POLL_EN
  parameter logic [9:0]  ADDR_FPGA_INFO      = 10'h001,
`endif
  parameter logic [9:0]  ADDR_EC_SYNC_TIME_0 = 10'h011,
  parameter logic [9:0]  ADDR_CYCLE_BASE     = 10'h100,
  parameter int unsigned SYNC_BIT            = 8,
  parameter int unsigned TIMEOUT             = 4096
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [9:0]       REQ_ADDR,
  input  logic [15:0]      REQ_DATA,
  input  logic             SYNC_REQ,
  input  logic [63:0]      SYNC_TIME,
  input  logic             CYC_VALID,
  output logic             CYC_READY,
  input  logic [WIDTH-1:0] CYC_DATA,
  output logic             SYNC_BUSY,
  output logic             SYNC_DONE,
  output logic             SYNC_ERR,
  output logic             CTL_EN,
  output logic             WE,
  output logic [9:0]       BRAM_ADDR,
  output logic [15:0]      DATA_IN,
`ifdef CTL_BUS_WRITER_THERMO_POLL_EN
  output logic             THERMO_OUT,
`endif
  input  logic [15:0]      DATA_OUT
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned WW = $clog2(RD_LATENCY + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
  localparam logic [PW-1:0] LAST_POLL = PW'(TIMEOUT - 1);
  localparam logic [WW-1:0] RD_LAST   = WW'(RD_LATENCY);
  localparam logic [15:0]   SYNC_MASK = 16'(1) << SYNC_BIT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC_TIME_WR,
    S_CYCLE_WR,
    S_RD_CTL,
    S_SET_SYNC,
    S_POLL
`ifdef CTL_BUS_WRITER_THERMO_POLL_EN
    , S_THERMO_RD
`endif
  } state_e;

  state_e        state_q;
  logic          ready_en_q;
  logic [63:0]   sync_time_q;
  logic [1:0]    k_q;
  logic [IW-1:0] idx_q;
  logic [PW-1:0] poll_q;
  logic [15:0]   v_q;
  logic          rd_pend_q;
  logic [WW-1:0] rd_wait_q;
  logic          ctl_en_q, we_q;
  logic [9:0]    addr_q;
  logic [15:0]   wdata_q;
  logic          busy_q, done_q, err_q;
  logic          rd_done;
`ifdef CTL_BUS_WRITER_THERMO_POLL_EN
  logic [15:0]   thermo_cnt_q;
  logic          thermo_pend_q;
  logic          thermo_q;
`endif

  // DATA_OUT holds the read result in the cycle RD_LATENCY after the read was on the bus.
  assign rd_done   = rd_pend_q && (rd_wait_q == RD_LAST);
  assign REQ_READY = ready_en_q && (state_q == S_IDLE) && !SYNC_REQ;
  assign CYC_READY = (state_q == S_CYCLE_WR);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      ready_en_q  <= 1'b0;
      sync_time_q <= '0;
      k_q         <= '0;
      idx_q       <= '0;
      poll_q      <= '0;
      v_q         <= '0;
      rd_pend_q   <= 1'b0;
      rd_wait_q   <= '0;
      ctl_en_q    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef CTL_BUS_WRITER_THERMO_POLL_EN
      thermo_cnt_q  <= '0;
      thermo_pend_q <= 1'b0;
      thermo_q      <= 1'b0;
`endif
    end else begin
      ready_en_q <= 1'b1;
      ctl_en_q   <= 1'b0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      if (rd_pend_q && !rd_done) rd_wait_q <= rd_wait_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          if (ready_en_q && SYNC_REQ) begin
            sync_time_q <= SYNC_TIME;
            busy_q      <= 1'b1;
            k_q         <= '0;
            state_q     <= S_SYNC_TIME_WR;
          end else if (ready_en_q && REQ_VALID) begin
            ctl_en_q <= 1'b1;
            we_q     <= 1'b1;
            addr_q   <= REQ_ADDR;
            wdata_q  <= REQ_DATA;
          end
`ifdef CTL_BUS_WRITER_THERMO_POLL_EN
          else if (ready_en_q && thermo_pend_q) begin
            thermo_pend_q <= 1'b0;
            rd_pend_q     <= 1'b0;
            state_q       <= S_THERMO_RD;
          end
`endif
        end

        S_SYNC_TIME_WR: begin
          ctl_en_q <= 1'b1;
          we_q     <= 1'b1;
          addr_q   <= ADDR_EC_SYNC_TIME_0 + 10'(k_q);
          wdata_q  <= sync_time_q[{k_q, 4'b0000} +: 16];
          k_q      <= k_q + 2'd1;
          if (k_q == 2'd3) begin
            idx_q   <= '0;
            state_q <= S_CYCLE_WR;
          end
        end

        S_CYCLE_WR: begin
          if (CYC_VALID) begin
            ctl_en_q <= 1'b1;
            we_q     <= 1'b1;
            addr_q   <= ADDR_CYCLE_BASE + 10'(idx_q);
            wdata_q  <= 16'(CYC_DATA);
            idx_q    <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              rd_pend_q <= 1'b0;
              state_q   <= S_RD_CTL;
            end
          end
        end

        S_RD_CTL: begin
          if (!rd_pend_q) begin
            ctl_en_q  <= 1'b1;
            addr_q    <= ADDR_CTL_REG;
            rd_pend_q <= 1'b1;
            rd_wait_q <= '0;
          end else if (rd_done) begin
            v_q       <= DATA_OUT;
            rd_pend_q <= 1'b0;
            state_q   <= S_SET_SYNC;
          end
        end

        S_SET_SYNC: begin
          ctl_en_q <= 1'b1;
          we_q     <= 1'b1;
          addr_q   <= ADDR_CTL_REG;
          wdata_q  <= v_q | SYNC_MASK;
          poll_q   <= '0;
          state_q  <= S_POLL;
        end

        // Timeout is counted in cycles, independent of how many reads were issued.
        S_POLL: begin
          if (poll_q == LAST_POLL) begin
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            poll_q <= poll_q + 1'b1;
            if (!rd_pend_q) begin
              ctl_en_q  <= 1'b1;
              addr_q    <= ADDR_CTL_REG;
              rd_pend_q <= 1'b1;
              rd_wait_q <= '0;
            end else if (rd_done) begin
              rd_pend_q <= 1'b0;
              if (!DATA_OUT[SYNC_BIT]) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end
          end
        end

`ifdef CTL_BUS_WRITER_THERMO_POLL_EN
        S_THERMO_RD: begin
          if (!rd_pend_q) begin
            ctl_en_q  <= 1'b1;
            addr_q    <= ADDR_FPGA_INFO;
            rd_pend_q <= 1'b1;
            rd_wait_q <= '0;
          end else if (rd_done) begin
            thermo_q  <= DATA_OUT[0];
            rd_pend_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
`endif

        default: state_q <= S_IDLE;
      endcase

`ifdef CTL_BUS_WRITER_THERMO_POLL_EN
      thermo_cnt_q <= thermo_cnt_q + 16'd1;
      if (thermo_cnt_q == '1) thermo_pend_q <= 1'b1;
`endif
    end
  end

  assign CTL_EN    = ctl_en_q;
  assign WE        = we_q;
  assign BRAM_ADDR = addr_q;
  assign DATA_IN   = wdata_q;
  assign SYNC_BUSY = busy_q;
  assign SYNC_DONE = done_q;
  assign SYNC_ERR  = err_q;
`ifdef CTL_BUS_WRITER_THERMO_POLL_EN
  assign THERMO_OUT = thermo_q;
`endif

endmodule

// File: tb/tb_ctl_bus_writer.sv
// Scoreboard bench for ctl_bus_writer: bus writes are queued when stimulus is driven and popped by a monitor.
module tb_ctl_bus_writer;
  localparam int unsigned WIDTH      = 13;
  localparam int unsigned DEPTH      = 249;
  localparam int unsigned RD_LATENCY = 2;
  localparam int unsigned SYNC_BIT   = 8;
  localparam int unsigned TIMEOUT    = 4096;
  localparam logic [9:0]  A_CTL      = 10'h000;
  localparam logic [9:0]  A_ST       = 10'h011;
  localparam logic [9:0]  A_CYC      = 10'h100;

  typedef struct packed {
    logic [9:0]  a;
    logic [15:0] d;
  } wr_t;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b1;
  logic             REQ_VALID = 1'b0;
  logic             REQ_READY;
  logic [9:0]       REQ_ADDR = '0;
  logic [15:0]      REQ_DATA = '0;
  logic             SYNC_REQ = 1'b0;
  logic [63:0]      SYNC_TIME = '0;
  logic             CYC_VALID = 1'b0;
  logic             CYC_READY;
  logic [WIDTH-1:0] CYC_DATA = '0;
  logic             SYNC_BUSY, SYNC_DONE, SYNC_ERR;
  logic             CTL_EN, WE;
  logic [9:0]       BRAM_ADDR;
  logic [15:0]      DATA_IN;
  logic [15:0]      DATA_OUT;

  int  checks = 0;
  int  errors = 0;
  int  done_cnt = 0;
  int  err_cnt = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  logic        ctl_load = 1'b0;
  logic [15:0] ctl_load_val = '0;
  logic        ctl_clear = 1'b0;
  logic [15:0] ctl_reg = '0;
  logic [15:0] rd_pipe [RD_LATENCY];

  ctl_bus_writer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LATENCY(RD_LATENCY), .SYNC_BIT(SYNC_BIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .SYNC_REQ(SYNC_REQ), .SYNC_TIME(SYNC_TIME),
    .CYC_VALID(CYC_VALID), .CYC_READY(CYC_READY), .CYC_DATA(CYC_DATA),
    .SYNC_BUSY(SYNC_BUSY), .SYNC_DONE(SYNC_DONE), .SYNC_ERR(SYNC_ERR),
    .CTL_EN(CTL_EN), .WE(WE), .BRAM_ADDR(BRAM_ADDR), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT)
  );

  always #5 CLK = ~CLK;

  // CTL_REG model with a RD_LATENCY read pipeline; other addresses read as zero.
  assign DATA_OUT = rd_pipe[RD_LATENCY-1];
  always @(posedge CLK) begin
    if (ctl_load) ctl_reg <= ctl_load_val;
    else if (ctl_clear) ctl_reg[SYNC_BIT] <= 1'b0;
    else if (CTL_EN && WE && BRAM_ADDR == A_CTL) ctl_reg <= DATA_IN;
    rd_pipe[0] <= (CTL_EN && !WE && BRAM_ADDR == A_CTL) ? ctl_reg : 16'h0000;
    for (int p = 1; p < int'(RD_LATENCY); p++) rd_pipe[p] <= rd_pipe[p-1];
  end

  always @(negedge CLK) begin
    if (RST_N) begin
      if (CTL_EN && WE) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bus_write unexpected addr=%h data=%h, none required", BRAM_ADDR, DATA_IN);
        end else begin
          mon_e = exp_q.pop_front();
          if (BRAM_ADDR !== mon_e.a || DATA_IN !== mon_e.d) begin
            errors++;
            $display("FAIL bus_write got addr=%h data=%h required addr=%h data=%h",
                     BRAM_ADDR, DATA_IN, mon_e.a, mon_e.d);
          end
        end
      end else if (CTL_EN) begin
        checks++;
        if (BRAM_ADDR !== A_CTL) begin
          errors++;
          $display("FAIL bus_read addr=%h required %h", BRAM_ADDR, A_CTL);
        end
      end
      if (SYNC_DONE) done_cnt++;
      if (SYNC_ERR) err_cnt++;
    end
  end

  function automatic logic [WIDTH-1:0] pat(input int i, input bit scr);
    return scr ? WIDTH'(i * 37 + 5) : WIDTH'(i);
  endfunction

  task automatic push_wr(input logic [9:0] a, input logic [15:0] d);
    wr_t x;
    x.a = a;
    x.d = d;
    exp_q.push_back(x);
  endtask

  task automatic do_sync(input logic [63:0] t, input int stall_at, input int abort_at,
                         input int ghost_at, input logic [15:0] ctl_init, input bit clear_it,
                         input bit with_req, input bit scr);
    int i, n, k, stall_hits;
    bit stalled, busy_ok;
    i = 0; stalled = 0; busy_ok = 1; stall_hits = 0;
    @(negedge CLK); ctl_load = 1'b1; ctl_load_val = ctl_init;
    @(negedge CLK); ctl_load = 1'b0;
    SYNC_REQ = 1'b1; SYNC_TIME = t;
    if (with_req) begin REQ_VALID = 1'b1; REQ_ADDR = 10'h033; REQ_DATA = 16'h5555; end
    #1;
    checks++;
    if (REQ_READY !== 1'b0) begin errors++; $display("FAIL sync_prio_ready got %b required 0", REQ_READY); end
    for (int w = 0; w < 4; w++) push_wr(A_ST + 10'(w), t[16*w +: 16]);
    @(negedge CLK); SYNC_REQ = 1'b0; REQ_VALID = 1'b0; SYNC_TIME = ~t;
    checks++;
    if (SYNC_BUSY !== 1'b1) begin errors++; $display("FAIL sync_busy_rise got %b required 1", SYNC_BUSY); end
    n = 0;
    while (i < int'(DEPTH) && n < 2000) begin
      if (i == abort_at) return;
      if (i == stall_at && !stalled) begin
        for (int s = 0; s < 5; s++) begin
          CYC_VALID = 1'b0;
          if (s > 0 && CTL_EN === 1'b1) stall_hits++;
          @(negedge CLK); n++;
        end
        if (CTL_EN === 1'b1) stall_hits++;
        stalled = 1;
        checks++;
        if (stall_hits != 0) begin errors++; $display("FAIL stall_bus_access got %0d required 0", stall_hits); end
      end
      CYC_VALID = 1'b1; CYC_DATA = pat(i, scr);
      SYNC_REQ = (i == ghost_at);
      if (SYNC_REQ) SYNC_TIME = 64'hFFFF_0000_FFFF_0000;
      if (CYC_READY === 1'b1) begin
        push_wr(A_CYC + 10'(i), 16'(pat(i, scr)));
        i++;
      end
      @(negedge CLK); n++;
    end
    CYC_VALID = 1'b0; SYNC_REQ = 1'b0;
    checks++;
    if (i != int'(DEPTH)) begin errors++; $display("FAIL stream_entries got %0d required %0d", i, DEPTH); end
    push_wr(A_CTL, ctl_init | 16'h0100);
    n = 0;
    while (!(CTL_EN === 1'b1 && WE === 1'b1 && BRAM_ADDR === A_CTL) && n < 100) begin
      @(negedge CLK); n++;
    end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL set_write_wait got %0d cycles required <100", n); end
    k = 0;
    while (k < int'(TIMEOUT) + 100) begin
      ctl_clear = (clear_it && k == 300);
      @(negedge CLK); k++;
      if (SYNC_DONE === 1'b1 || SYNC_ERR === 1'b1) break;
      if (SYNC_BUSY !== 1'b1) busy_ok = 0;
    end
    ctl_clear = 1'b0;
    checks++;
    if (!busy_ok) begin errors++; $display("FAIL busy_held got drop required high"); end
    checks++;
    if (clear_it) begin
      if (SYNC_DONE !== 1'b1 || SYNC_ERR !== 1'b0) begin
        errors++; $display("FAIL sync_done got done=%b err=%b required done=1 err=0", SYNC_DONE, SYNC_ERR);
      end
    end else begin
      if (SYNC_ERR !== 1'b1 || SYNC_DONE !== 1'b0 || k != int'(TIMEOUT)) begin
        errors++;
        $display("FAIL sync_timeout got err=%b done=%b at %0d required err=1 done=0 at %0d",
                 SYNC_ERR, SYNC_DONE, k, TIMEOUT);
      end
    end
    @(negedge CLK);
    checks++;
    if (SYNC_DONE !== 1'b0 || SYNC_ERR !== 1'b0 || SYNC_BUSY !== 1'b0 || REQ_READY !== 1'b1) begin
      errors++;
      $display("FAIL sync_end got done=%b err=%b busy=%b ready=%b required 0 0 0 1",
               SYNC_DONE, SYNC_ERR, SYNC_BUSY, REQ_READY);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sync_leftover got %0d writes pending required 0", exp_q.size()); end
  endtask

  task automatic test_reset;
    #1 RST_N = 1'b0;
    #2;
    checks++;
    if ({CTL_EN, WE, BRAM_ADDR, DATA_IN, SYNC_BUSY, SYNC_DONE, SYNC_ERR, REQ_READY, CYC_READY} !== '0) begin
      errors++; $display("FAIL reset_outputs got en=%b we=%b addr=%h data=%h ready=%b required all 0",
                         CTL_EN, WE, BRAM_ADDR, DATA_IN, REQ_READY);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (REQ_READY !== 1'b1 || CTL_EN !== 1'b0) begin
      errors++; $display("FAIL reset_release got ready=%b en=%b required 1 0", REQ_READY, CTL_EN);
    end
  endtask

  task automatic test_single_write;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_ADDR = 10'h005; REQ_DATA = 16'hBEEF;
    checks++;
    if (REQ_READY !== 1'b1) begin errors++; $display("FAIL single_ready got %b required 1", REQ_READY); end
    push_wr(10'h005, 16'hBEEF);
    @(negedge CLK); REQ_VALID = 1'b0;
    checks++;
    if (CTL_EN !== 1'b1 || WE !== 1'b1 || BRAM_ADDR !== 10'h005 || DATA_IN !== 16'hBEEF) begin
      errors++; $display("FAIL single_write got en=%b we=%b addr=%h data=%h required 1 1 005 beef",
                         CTL_EN, WE, BRAM_ADDR, DATA_IN);
    end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    logic [9:0]  addrs [3];
    logic [15:0] datas [3];
    int hits;
    addrs[0] = 10'h2A5; addrs[1] = 10'h007; addrs[2] = 10'h3FF;
    datas[0] = 16'h1234; datas[1] = 16'h0000; datas[2] = 16'hFFFF;
    hits = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge CLK);
      if (j > 0 && CTL_EN === 1'b1 && WE === 1'b1) hits++;
      REQ_VALID = 1'b1; REQ_ADDR = addrs[j]; REQ_DATA = datas[j];
      push_wr(addrs[j], datas[j]);
    end
    @(negedge CLK); REQ_VALID = 1'b0;
    if (CTL_EN === 1'b1 && WE === 1'b1) hits++;
    checks++;
    if (hits != 3) begin errors++; $display("FAIL back_to_back got %0d consecutive writes required 3", hits); end
    @(negedge CLK);
    checks++;
    if (CTL_EN !== 1'b0) begin errors++; $display("FAIL back_to_back_idle got en=%b required 0", CTL_EN); end
  endtask

  task automatic test_sync_done;
    do_sync(64'h0123_4567_89AB_CDEF, -1, -1, 20, 16'h0003, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_stall;
    do_sync(64'hA5A5_5A5A_0F0F_F0F0, 100, -1, -1, 16'h00F0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    do_sync(64'hFEDC_BA98_7654_3210, -1, -1, -1, 16'h0040, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    do_sync(64'h1111_2222_3333_4444, -1, 50, -1, 16'h0003, 1'b1, 1'b0, 1'b0);
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({CTL_EN, WE, BRAM_ADDR, DATA_IN, SYNC_BUSY, SYNC_DONE, SYNC_ERR, REQ_READY, CYC_READY} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs got en=%b we=%b busy=%b cyc_ready=%b required all 0",
                         CTL_EN, WE, SYNC_BUSY, CYC_READY);
    end
    CYC_VALID = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
    checks++;
    if (done_cnt != d0 || err_cnt != e0 || REQ_READY !== 1'b1 || SYNC_BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_mid_after got done=%0d err=%0d ready=%b required done=%0d err=%0d ready=1",
                         done_cnt, err_cnt, REQ_READY, d0, e0);
    end
    do_sync(64'h0BAD_F00D_CAFE_1234, -1, -1, -1, 16'h0003, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_sync_done();
    test_stall();
    test_timeout();
    test_reset_mid();
    repeat (5) @(negedge CLK);
    checks++;
    if (done_cnt != 3 || err_cnt != 1) begin
      errors++; $display("FAIL pulse_totals got done=%0d err=%0d required done=3 err=1", done_cnt, err_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
